gpio_wb_bridge: RTL and testbench

GPIO_WB_BRIDGE -- requirements
Module: gpio_wb_bridge

---
 rtl/gpio_wb_bridge_pkg.sv | 21 ++
 rtl/gpio_wb_bridge_ram_arb.sv | 37 +++
 rtl/gpio_wb_bridge.sv | 135 +++++++++++++
 tb/tb_gpio_wb_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_wb_bridge_pkg.sv
// Shared definitions for the GPIO Wishbone bridge: FSM encoding, region map
// and the helper that classifies a 4 KiB block offset.
package gpio_wb_bridge_pkg;

  typedef enum logic [2:0] {StIdle, StCtrl, StRamReq, StRamData, StAck} state_e;

  typedef enum logic [1:0] {RegCtrl, RegRam, RegHole} region_e;

  localparam logic [11:0] CtrlOffset  = 12'h000;
  localparam logic [11:0] RamOffset   = 12'h100;
  localparam int unsigned RamWords    = 32;
  localparam int unsigned RamSpanBits = $clog2(RamWords * 4);

  // Control registers occupy the first 16 bytes; RAM window is RamWords words.
  function automatic region_e decode_region(input logic [11:0] offset);
    if (offset[11:4] == CtrlOffset[11:4]) return RegCtrl;
    if (offset[11:RamSpanBits] == RamOffset[11:RamSpanBits]) return RegRam;
    return RegHole;
  endfunction

endpackage

// File: rtl/gpio_wb_bridge_ram_arb.sv
// Sample RAM port mux: the GPIO core always wins; the Wishbone host is granted
// only in cycles where the core leaves the RAM idle.
module gpio_ram_arb (
  input  logic        core_csb,
  input  logic        core_web,
  input  logic [7:0]  core_addr,
  input  logic [31:0] core_data,
  input  logic        host_req,
  input  logic        host_web,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  output logic        host_grant,
  output logic        ram_csb,
  output logic        ram_web,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_data
);

  assign host_grant = host_req & core_csb;

  always_comb begin
    ram_csb  = core_csb;
    ram_web  = core_web;
    ram_addr = core_addr;
    ram_data = core_data;
    if (host_grant) begin
      ram_csb  = 1'b0;
      ram_web  = host_web;
      ram_addr = host_addr;
      ram_data = host_data;
    end else if (core_csb) begin
      // Core idle and no host grant: keep the RAM deselected.
      ram_web = 1'b1;
    end
  end

endmodule

// File: rtl/gpio_wb_bridge.sv
// Wishbone classic slave exposing the GPIO controller registers and a window
// onto its sample RAM, which is shared with the controller core.
module gpio_wb_bridge
  import gpio_wb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        CTRL_WE,
  output logic [3:0]  CTRL_ADDR,
  output logic [31:0] CTRL_DATA_IN,
  input  logic [31:0] CTRL_DATA_OUT,
  input  logic        CORE_RAM_CSb,
  input  logic        CORE_RAM_WEb,
  input  logic [7:0]  CORE_RAM_ADDR,
  input  logic [31:0] CORE_RAM_DATA_IN,
  output logic        RAM_CSb,
  output logic        RAM_WEb,
  output logic [7:0]  RAM_ADDR,
  output logic [31:0] RAM_DATA_IN,
  input  logic [31:0] RAM_DATA_OUT
);

  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] dat_q, dat_d;
  logic        hit, sel_full, host_req, host_grant;
  region_e     region;

  assign hit      = wb_cyc_i & wb_stb_i & (wb_adr_i[31:12] == BASE_ADDR[31:12]);
  assign region   = decode_region(wb_adr_i[11:0]);
  assign sel_full = (wb_sel_i == 4'hF);
  // Requesting only while the cycle is alive keeps an abandoned access off the RAM.
  assign host_req = (state_q == StRamReq) & wb_cyc_i;

  gpio_ram_arb u_ram_arb (
    .core_csb   (CORE_RAM_CSb),
    .core_web   (CORE_RAM_WEb),
    .core_addr  (CORE_RAM_ADDR),
    .core_data  (CORE_RAM_DATA_IN),
    .host_req   (host_req),
    .host_web   (~(wb_we_i & sel_full)),
    .host_addr  ({1'b0, wb_adr_i[6:2], 2'b00}),
    .host_data  (wb_dat_i),
    .host_grant (host_grant),
    .ram_csb    (RAM_CSb),
    .ram_web    (RAM_WEb),
    .ram_addr   (RAM_ADDR),
    .ram_data   (RAM_DATA_IN)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    dat_d   = dat_q;
    CTRL_WE = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          // Cleared here so hole reads and RAM timeouts return zero.
          dat_d = '0;
          case (region)
            RegCtrl: state_d = StCtrl;
            RegRam: begin
              wait_d  = '0;
              state_d = StRamReq;
            end
            default: state_d = StAck;
          endcase
        end
      end
      StCtrl: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          CTRL_WE = wb_we_i & sel_full;
          if (!wb_we_i) dat_d = CTRL_DATA_OUT;
          state_d = StAck;
        end
      end
      StRamReq: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (host_grant) begin
          state_d = wb_we_i ? StAck : StRamData;
        end else if (wait_q == WaitLimit) begin
          dat_d   = '0;
          state_d = StAck;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StRamData: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          dat_d   = RAM_DATA_OUT;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= StIdle;
      wait_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_ack_o     = (state_q == StAck);
  assign wb_dat_o     = dat_q;
  assign CTRL_ADDR    = wb_adr_i[3:0];
  assign CTRL_DATA_IN = wb_dat_i;

endmodule

// File: tb/tb_gpio_wb_bridge.sv
// Directed bench for gpio_wb_bridge: control registers, RAM window, core
// contention, timeout, holes, non-hits, aborted cycles and reset.
module tb_gpio_wb_bridge;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        cyc, cyc2, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        core_csb, core_web;
  logic [7:0]  core_addr;
  logic [31:0] core_data;

  logic [31:0] dat_o, dat2_o;
  logic        ack, ack2;
  logic        ctrl_we, ctrl_we2;
  logic [3:0]  ctrl_addr, ctrl_addr2;
  logic [31:0] ctrl_din, ctrl_din2;
  logic [31:0] ctrl_dout, ctrl_dout2;
  logic        ram_csb, ram_web, ram_csb2, ram_web2;
  logic [7:0]  ram_addr, ram_addr2;
  logic [31:0] ram_din, ram_din2;
  logic [31:0] ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Control register file stand-in: combinational read data from the address.
  assign ctrl_dout  = (ctrl_addr == 4'h4) ? 32'hA5A5_0001 : {28'h1111_000, ctrl_addr};
  assign ctrl_dout2 = 32'h0BAD_0BAD;

  // Sample RAM: synchronous, read data valid one cycle after select.
  logic [31:0] mem [0:63];
  always @(posedge CLK) begin
    if (!ram_csb) begin
      if (!ram_web) mem[ram_addr[7:2]] <= ram_din;
      ram_dout <= mem[ram_addr[7:2]];
    end
  end

  gpio_wb_bridge #(.BASE_ADDR(Base), .WAIT_LIMIT(255)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .CTRL_WE(ctrl_we), .CTRL_ADDR(ctrl_addr), .CTRL_DATA_IN(ctrl_din),
    .CTRL_DATA_OUT(ctrl_dout),
    .CORE_RAM_CSb(core_csb), .CORE_RAM_WEb(core_web), .CORE_RAM_ADDR(core_addr),
    .CORE_RAM_DATA_IN(core_data),
    .RAM_CSb(ram_csb), .RAM_WEb(ram_web), .RAM_ADDR(ram_addr), .RAM_DATA_IN(ram_din),
    .RAM_DATA_OUT(ram_dout)
  );

  // Short wait limit for the timeout case; its own cycle line keeps it quiet otherwise.
  gpio_wb_bridge #(.BASE_ADDR(Base), .WAIT_LIMIT(4)) dut_to (
    .CLK(CLK), .RSTb(RSTb),
    .wb_cyc_i(cyc2), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat2_o), .wb_ack_o(ack2),
    .CTRL_WE(ctrl_we2), .CTRL_ADDR(ctrl_addr2), .CTRL_DATA_IN(ctrl_din2),
    .CTRL_DATA_OUT(ctrl_dout2),
    .CORE_RAM_CSb(core_csb), .CORE_RAM_WEb(core_web), .CORE_RAM_ADDR(core_addr),
    .CORE_RAM_DATA_IN(core_data),
    .RAM_CSb(ram_csb2), .RAM_WEb(ram_web2), .RAM_ADDR(ram_addr2), .RAM_DATA_IN(ram_din2),
    .RAM_DATA_OUT(32'hDEAD_BEEF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_start(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
  endtask

  task automatic wb_end();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc;
    logic host_seen;
    RSTb = 1'b0; cyc = 0; cyc2 = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    core_csb = 1'b0; core_web = 1'b1; core_addr = 8'h55; core_data = 32'h0;
    #12;
    // Reset: core pass-through on the RAM port, everything else quiet.
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_ctrl_we", {31'd0, ctrl_we}, 32'd0);
    check("rst_ram_csb_core", {31'd0, ram_csb}, 32'd0);
    check("rst_ram_addr_core", {24'd0, ram_addr}, 32'h55);
    core_csb = 1'b1;
    #1;
    check("rst_ram_csb_idle", {31'd0, ram_csb}, 32'd1);
    check("rst_ram_web_idle", {31'd0, ram_web}, 32'd1);
    step();
    RSTb = 1'b1;
    step();

    // Control register write.
    wb_start(1'b1, 4'hF, Base + 32'h0, 32'h1000_0041);
    step();
    check("cw_we_c1", {31'd0, ctrl_we}, 32'd1);
    check("cw_addr_c1", {28'd0, ctrl_addr}, 32'h0);
    check("cw_din_c1", ctrl_din, 32'h1000_0041);
    check("cw_ack_c1", {31'd0, ack}, 32'd0);
    step();
    check("cw_ack_c2", {31'd0, ack}, 32'd1);
    check("cw_we_c2", {31'd0, ctrl_we}, 32'd0);
    wb_end();
    step();
    check("cw_ack_after", {31'd0, ack}, 32'd0);

    // Control register read.
    wb_start(1'b0, 4'hF, Base + 32'h4, 32'h0);
    step();
    check("cr_we_c1", {31'd0, ctrl_we}, 32'd0);
    check("cr_ack_c1", {31'd0, ack}, 32'd0);
    step();
    check("cr_ack_c2", {31'd0, ack}, 32'd1);
    check("cr_dat", dat_o, 32'hA5A5_0001);
    wb_end();
    step();

    // RAM write then read back.
    wb_start(1'b1, 4'hF, Base + 32'h108, 32'hCAFE_F00D);
    step();
    check("rw_csb", {31'd0, ram_csb}, 32'd0);
    check("rw_web", {31'd0, ram_web}, 32'd0);
    check("rw_addr", {24'd0, ram_addr}, 32'h08);
    check("rw_din", ram_din, 32'hCAFE_F00D);
    check("rw_ack_c1", {31'd0, ack}, 32'd0);
    step();
    check("rw_ack_c2", {31'd0, ack}, 32'd1);
    check("rw_csb_ack", {31'd0, ram_csb}, 32'd1);
    wb_end();
    step();
    wb_start(1'b0, 4'hF, Base + 32'h108, 32'h0);
    step();
    check("rr_csb", {31'd0, ram_csb}, 32'd0);
    check("rr_web", {31'd0, ram_web}, 32'd1);
    check("rr_addr", {24'd0, ram_addr}, 32'h08);
    check("rr_ack_c1", {31'd0, ack}, 32'd0);
    step();
    check("rr_ack_c2", {31'd0, ack}, 32'd0);
    step();
    check("rr_ack_c3", {31'd0, ack}, 32'd1);
    check("rr_dat", dat_o, 32'hCAFE_F00D);
    wb_end();
    step();

    // Core holds the RAM for 10 cycles during a host read.
    core_csb = 1'b0; core_web = 1'b1; core_addr = 8'h44;
    wb_start(1'b0, 4'hF, Base + 32'h108, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("ct_core_addr", {24'd0, ram_addr}, 32'h44);
      check("ct_ack_wait", {31'd0, ack}, 32'd0);
    end
    core_csb = 1'b1;
    #1;
    check("ct_grant_csb", {31'd0, ram_csb}, 32'd0);
    check("ct_grant_addr", {24'd0, ram_addr}, 32'h08);
    step();
    check("ct_ack_c12", {31'd0, ack}, 32'd0);
    step();
    check("ct_ack_c13", {31'd0, ack}, 32'd1);
    check("ct_dat", dat_o, 32'hCAFE_F00D);
    wb_end();
    step();

    // Permanent core ownership with WAIT_LIMIT=4: timeout ack, zero data.
    core_csb = 1'b0; core_addr = 8'h44;
    cyc2 = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = Base + 32'h100;
    ack_cyc = 0;
    host_seen = 1'b0;
    for (int i = 1; i <= 20 && ack_cyc == 0; i++) begin
      step();
      if (ram_addr2 != 8'h44) host_seen = 1'b1;
      if (ack2) ack_cyc = i;
    end
    check("to_ack_window", {31'd0, (ack_cyc >= 5 && ack_cyc <= 7)}, 32'd1);
    check("to_dat", dat2_o, 32'h0);
    check("to_no_host", {31'd0, host_seen}, 32'd0);
    cyc2 = 1'b0; stb = 1'b0;
    core_csb = 1'b1;
    step();

    // Byte write to a control register: acked, no strobe.
    wb_start(1'b1, 4'h1, Base + 32'h0, 32'h0000_00FF);
    step();
    check("bw_we_c1", {31'd0, ctrl_we}, 32'd0);
    step();
    check("bw_ack", {31'd0, ack}, 32'd1);
    check("bw_we_c2", {31'd0, ctrl_we}, 32'd0);
    wb_end();
    step();

    // Hole read returns zero with a one-cycle ack.
    wb_start(1'b0, 4'hF, Base + 32'h40, 32'h0);
    step();
    check("hole_ack", {31'd0, ack}, 32'd1);
    check("hole_dat", dat_o, 32'h0);
    wb_end();
    step();

    // Non-hit address: never acknowledged.
    wb_start(1'b0, 4'hF, 32'h4000_0000, 32'h0);
    ack_cyc = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (ack) ack_cyc = i;
    end
    check("nohit_ack", ack_cyc, 32'd0);
    wb_end();
    step();

    // Cycle dropped during a RAM read: no ack.
    wb_start(1'b0, 4'hF, Base + 32'h108, 32'h0);
    step();
    wb_end();
    ack_cyc = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (ack) ack_cyc = i;
    end
    check("abort_ack", ack_cyc, 32'd0);

    // Reset mid-transaction: aborted, no ack.
    wb_start(1'b0, 4'hF, Base + 32'h4, 32'h0);
    step();
    RSTb = 1'b0;
    #1;
    check("rstmid_ack", {31'd0, ack}, 32'd0);
    check("rstmid_dat", dat_o, 32'h0);
    wb_end();
    step();
    RSTb = 1'b1;
    step();
    check("rstmid_ack_after", {31'd0, ack}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
